mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch (IF) and load/store (MEM).
// MEM has priority, but IF is forced after STARVE_MAX consecutive MEM wins.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        ifReq,
    input  logic [31:0] ifAddr,
    output logic        ifValid,
    output logic [31:0] ifData,
    input  logic        memReq,
    input  logic        memWe,
    input  logic [2:0]  memFunc3,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWdata,
    output logic        memValid,
    output logic [31:0] memRdata,
    output logic        memMisalign,
    input  logic        flush,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [3:0]  busBe,
    output logic [31:0] busWdata,
    input  logic        busGnt,
    input  logic        busRvalid,
    input  logic [31:0] busRdata
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  starve_q, starve_d;
    logic        drop_q, drop_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_data_q, if_data_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_mis_q, mem_mis_d;
    logic        mem_win_s;
    logic        unused_if_lane_s;

    // Fetches are always word-aligned on the bus, so the low address bits carry no information.
    assign unused_if_lane_s = ^ifAddr[1:0];

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = lane[0];
            3'b010:         misaligned = (lane != 2'b00);
            default:        misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << lane;
            2'b01:   store_be = 4'b0011 << {lane[1], 1'b0};
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'd0, b};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = rd;
        endcase
    endfunction

    assign mem_win_s = memReq && (!ifReq || (starve_q < 3'(STARVE_MAX)));

    // Next-state, arbitration and response-capture logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        func3_d     = func3_q;
        lane_d      = lane_q;
        starve_d    = starve_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        if_valid_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_valid_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_mis_d   = mem_mis_q;
        // A flush only ever poisons a fetch that already owns the bus.
        drop_d      = drop_q | (flush && (owner_q == OWN_IF) && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (mem_win_s) begin
                    owner_d  = OWN_MEM;
                    func3_d  = memFunc3;
                    lane_d   = memAddr[1:0];
                    starve_d = (ifReq && (starve_q != 3'd7)) ? (starve_q + 3'd1) : starve_q;
                    if (misaligned(memFunc3, memAddr[1:0])) begin
                        state_d     = S_RESP;
                        mem_valid_d = 1'b1;
                        mem_rdata_d = 32'd0;
                        mem_mis_d   = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        bus_req_d   = 1'b1;
                        bus_we_d    = memWe;
                        bus_addr_d  = {memAddr[31:2], 2'b00};
                        bus_be_d    = memWe ? store_be(memFunc3, memAddr[1:0]) : 4'b1111;
                        bus_wdata_d = store_data(memFunc3, memWdata);
                    end
                end else if (ifReq) begin
                    owner_d     = OWN_IF;
                    starve_d    = 3'd0;
                    state_d     = S_ISSUE;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = {ifAddr[31:2], 2'b00};
                    bus_be_d    = 4'b1111;
                    bus_wdata_d = 32'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (busGnt) begin
                    state_d   = S_WAIT;
                    bus_req_d = 1'b0;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (busRvalid) begin
                    state_d = S_RESP;
                    if (owner_q == OWN_MEM) begin
                        mem_valid_d = 1'b1;
                        mem_rdata_d = load_extract(func3_q, lane_q, busRdata);
                        mem_mis_d   = 1'b0;
                    end else if (!drop_d) begin
                        if_valid_d = 1'b1;
                        if_data_d  = busRdata;
                    end else begin
                        if_valid_d = 1'b0;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; everything clears on reset.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            func3_q     <= 3'd0;
            lane_q      <= 2'd0;
            starve_q    <= 3'd0;
            drop_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            if_valid_q  <= 1'b0;
            if_data_q   <= 32'd0;
            mem_valid_q <= 1'b0;
            mem_rdata_q <= 32'd0;
            mem_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            func3_q     <= func3_d;
            lane_q      <= lane_d;
            starve_q    <= starve_d;
            drop_q      <= drop_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            if_valid_q  <= if_valid_d;
            if_data_q   <= if_data_d;
            mem_valid_q <= mem_valid_d;
            mem_rdata_q <= mem_rdata_d;
            mem_mis_q   <= mem_mis_d;
        end
    end

    assign busReq      = bus_req_q;
    assign busWe       = bus_we_q;
    assign busAddr     = bus_addr_q;
    assign busBe       = bus_be_q;
    assign busWdata    = bus_wdata_q;
    assign ifValid     = if_valid_q;
    assign ifData      = if_data_q;
    assign memValid    = mem_valid_q;
    assign memRdata    = mem_rdata_q;
    assign memMisalign = mem_mis_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected bus requests and responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        ifReq = 1'b0;
    logic [31:0] ifAddr = 32'd0;
    logic        ifValid;
    logic [31:0] ifData;
    logic        memReq = 1'b0;
    logic        memWe = 1'b0;
    logic [2:0]  memFunc3 = 3'd0;
    logic [31:0] memAddr = 32'd0;
    logic [31:0] memWdata = 32'd0;
    logic        memValid;
    logic [31:0] memRdata;
    logic        memMisalign;
    logic        flush = 1'b0;
    logic        busReq, busWe;
    logic [31:0] busAddr, busWdata;
    logic [3:0]  busBe;
    logic        busGnt = 1'b0;
    logic        busRvalid = 1'b0;
    logic [31:0] busRdata = 32'd0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .nRst(nRst),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifValid(ifValid), .ifData(ifData),
        .memReq(memReq), .memWe(memWe), .memFunc3(memFunc3), .memAddr(memAddr),
        .memWdata(memWdata), .memValid(memValid), .memRdata(memRdata),
        .memMisalign(memMisalign), .flush(flush),
        .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busBe(busBe),
        .busWdata(busWdata), .busGnt(busGnt), .busRvalid(busRvalid), .busRdata(busRdata)
    );

    typedef struct {
        logic        is_mem;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } bus_t;

    resp_t       exp_resp[$];
    bus_t        exp_bus[$];
    int          checks = 0;
    int          errors = 0;
    int          gnt_dly = 0;
    int          rv_dly = 0;
    logic [31:0] rd_data = 32'd0;
    logic        stray = 1'b0;
    int          phase = 0;
    int          dcnt = 0;
    logic        prev_busreq = 1'b0;
    int          if_pulses = 0;

    // Bus slave model: grant after gnt_dly cycles, complete after rv_dly more.
    always @(negedge clk) begin
        busGnt    = 1'b0;
        busRvalid = stray;
        if (stray) busRdata = 32'h5A5A5A5A;
        if (!nRst) begin
            phase = 0;
            dcnt  = 0;
        end else if (phase == 0) begin
            if (busReq) begin
                if (dcnt >= gnt_dly) begin
                    busGnt = 1'b1; phase = 1; dcnt = 0;
                end else dcnt++;
            end
        end else begin
            if (dcnt >= rv_dly) begin
                busRvalid = 1'b1; busRdata = rd_data; phase = 0; dcnt = 0;
            end else dcnt++;
        end
    end

    // Monitor: compares every response pulse and every new bus request against the queues.
    always @(negedge clk) begin
        resp_t r;
        bus_t  b;
        if (ifValid) begin
            if_pulses++;
            checks++;
            if (exp_resp.size() == 0) begin
                errors++;
                $display("FAIL if_unexpected ifValid with ifData=%h, nothing expected", ifData);
            end else begin
                r = exp_resp.pop_front();
                if (r.is_mem || ifData !== r.data) begin
                    errors++;
                    $display("FAIL if_resp got IF data=%h, expected %s data=%h",
                             ifData, r.is_mem ? "MEM" : "IF", r.data);
                end
            end
        end
        if (memValid) begin
            checks++;
            if (exp_resp.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected memValid with memRdata=%h, nothing expected", memRdata);
            end else begin
                r = exp_resp.pop_front();
                if (!r.is_mem || memMisalign !== r.mis || (r.chk_data && memRdata !== r.data)) begin
                    errors++;
                    $display("FAIL mem_resp got MEM data=%h mis=%b, expected %s data=%h mis=%b",
                             memRdata, memMisalign, r.is_mem ? "MEM" : "IF", r.data, r.mis);
                end
            end
        end
        if (busReq && !prev_busreq) begin
            checks++;
            if (exp_bus.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected busReq addr=%h be=%b", busAddr, busBe);
            end else begin
                b = exp_bus.pop_front();
                if (busAddr !== b.addr || busBe !== b.be || busWe !== b.we ||
                    (b.we && busWdata !== b.wdata)) begin
                    errors++;
                    $display("FAIL bus_req got addr=%h be=%b we=%b wdata=%h, expected addr=%h be=%b we=%b wdata=%h",
                             busAddr, busBe, busWe, busWdata, b.addr, b.be, b.we, b.wdata);
                end
            end
        end
        prev_busreq = busReq;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_resp(input logic is_mem, input logic [31:0] d, input logic chk, input logic mis);
        resp_t r;
        r.is_mem = is_mem; r.data = d; r.chk_data = chk; r.mis = mis;
        exp_resp.push_back(r);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic we);
        bus_t b;
        b.addr = a; b.be = be; b.wdata = wd; b.we = we;
        exp_bus.push_back(b);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_resp.size() != 0 || exp_bus.size() != 0) && n < budget) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (exp_resp.size() != 0 || exp_bus.size() != 0) begin
            errors++;
            $display("FAIL %s timeout pending_resp=%0d pending_bus=%0d", name, exp_resp.size(), exp_bus.size());
            exp_resp.delete();
            exp_bus.delete();
        end
    endtask

    // Drive one MEM request and hold it until memValid (or a cycle budget runs out).
    task automatic mem_op(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [31:0] exp_rd, input logic mis, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
        int n = 0;
        push_resp(1'b1, exp_rd, !we, mis);
        if (!mis) push_bus(addr & 32'hFFFF_FFFC, exp_be, exp_wd, we);
        rd_data = rd; memWe = we; memFunc3 = f3; memAddr = addr; memWdata = wd; memReq = 1'b1;
        do begin @(negedge clk); n++; end while (!memValid && n < 40);
        memReq = 1'b0;
        check({name, "_done"}, 32'(memValid), 32'd1);
        @(negedge clk);
    endtask

    task automatic if_op(input string name, input logic [31:0] addr, input logic [31:0] rd);
        int n = 0;
        push_resp(1'b0, rd, 1'b1, 1'b0);
        push_bus(addr & 32'hFFFF_FFFC, 4'b1111, 32'd0, 1'b0);
        rd_data = rd; ifAddr = addr; ifReq = 1'b1;
        do begin @(negedge clk); n++; end while (!ifValid && n < 40);
        ifReq = 1'b0;
        check({name, "_done"}, 32'(ifValid), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int base;
        // Reset with both requests raised: nothing may leak out.
        ifReq = 1'b1; memReq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busReq", 32'(busReq), 32'd0);
        check("rst_valids", {30'd0, ifValid, memValid}, 32'd0);
        check("rst_misalign", 32'(memMisalign), 32'd0);
        check("rst_ifData", ifData, 32'd0);
        check("rst_memRdata", memRdata, 32'd0);
        check("rst_bus_fields", busAddr | busWdata | 32'(busBe) | 32'(busWe), 32'd0);
        @(negedge clk);
        ifReq = 1'b0; memReq = 1'b0; nRst = 1'b1;
        @(negedge clk);

        // IF read of 0x100 with minimum latency.
        push_resp(1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
        push_bus(32'h100, 4'b1111, 32'd0, 1'b0);
        rd_data = 32'hDEADBEEF; ifAddr = 32'h100; ifReq = 1'b1;
        @(posedge clk); #1;
        check("lat_busReq_c1", 32'(busReq), 32'd1);
        @(posedge clk); #1;
        check("lat_noValid_c2", 32'(ifValid), 32'd0);
        @(posedge clk); #1;
        check("lat_ifValid_c3", 32'(ifValid), 32'd1);
        check("lat_ifData_c3", ifData, 32'hDEADBEEF);
        @(negedge clk);
        ifReq = 1'b0;
        @(negedge clk);

        // Flush while IF waits: bus completes, no ifValid, ifData holds.
        base = if_pulses;
        rv_dly = 2;
        push_bus(32'h500, 4'b1111, 32'd0, 1'b0);
        rd_data = 32'h99999999; ifAddr = 32'h500; ifReq = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1; ifReq = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        repeat (8) @(negedge clk);
        check("flush_no_ifValid", 32'(if_pulses - base), 32'd0);
        check("flush_ifData_hold", ifData, 32'hDEADBEEF);
        rv_dly = 0;
        if_op("if_after_flush", 32'h600, 32'h11112222);

        // Store/load lane handling.
        mem_op("sb_203", 1'b1, 3'b000, 32'h203, 32'h000000AB, 32'd0, 32'd0, 1'b0, 4'b1000, 32'hABABABAB);
        mem_op("lb_203", 1'b0, 3'b000, 32'h203, 32'd0, 32'h80000000, 32'hFFFFFF80, 1'b0, 4'b1111, 32'd0);
        mem_op("lbu_203", 1'b0, 3'b100, 32'h203, 32'd0, 32'h80000000, 32'h00000080, 1'b0, 4'b1111, 32'd0);
        mem_op("sh_102", 1'b1, 3'b001, 32'h102, 32'h00001234, 32'd0, 32'd0, 1'b0, 4'b1100, 32'h12341234);
        mem_op("lh_102", 1'b0, 3'b001, 32'h102, 32'd0, 32'h80010000, 32'hFFFF8001, 1'b0, 4'b1111, 32'd0);
        mem_op("lhu_102", 1'b0, 3'b101, 32'h102, 32'd0, 32'h80010000, 32'h00008001, 1'b0, 4'b1111, 32'd0);
        mem_op("lb_001", 1'b0, 3'b000, 32'h001, 32'd0, 32'h00007F00, 32'h0000007F, 1'b0, 4'b1111, 32'd0);
        gnt_dly = 2; rv_dly = 3;
        mem_op("sw_104", 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 32'd0, 32'd0, 1'b0, 4'b1111, 32'hCAFEF00D);
        mem_op("lw_104", 1'b0, 3'b010, 32'h104, 32'd0, 32'h13579BDF, 32'h13579BDF, 1'b0, 4'b1111, 32'd0);
        gnt_dly = 0; rv_dly = 0;

        // Misaligned LW skips the bus and answers the cycle after grant.
        push_resp(1'b1, 32'd0, 1'b1, 1'b1);
        memWe = 1'b0; memFunc3 = 3'b010; memAddr = 32'h102; memReq = 1'b1;
        @(posedge clk); #1;
        check("mis_lw_memValid", 32'(memValid), 32'd1);
        check("mis_lw_misalign", 32'(memMisalign), 32'd1);
        check("mis_lw_rdata", memRdata, 32'd0);
        check("mis_lw_no_busReq", 32'(busReq), 32'd0);
        @(negedge clk);
        memReq = 1'b0;
        @(negedge clk);
        mem_op("mis_sh_101", 1'b1, 3'b001, 32'h101, 32'h5555, 32'd0, 32'd0, 1'b1, 4'd0, 32'd0);
        mem_op("ill_f3_011", 1'b0, 3'b011, 32'h000, 32'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'd0);
        mem_op("ill_f3_110", 1'b0, 3'b110, 32'h000, 32'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'd0);
        mem_op("mis_lhu_003", 1'b0, 3'b101, 32'h003, 32'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'd0);

        // Flush has no effect on a MEM transaction.
        flush = 1'b1;
        mem_op("lw_700_flush", 1'b0, 3'b010, 32'h700, 32'd0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 4'b1111, 32'd0);
        flush = 1'b0;
        wait_drain("mem_phase", 20);

        // Starvation: both requests held -> MEM x4 then IF, twice.
        nRst = 1'b0;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4) begin
                push_resp(1'b0, 32'h12345678, 1'b1, 1'b0);
                push_bus(32'h400, 4'b1111, 32'd0, 1'b0);
            end else begin
                push_resp(1'b1, 32'h12345678, 1'b1, 1'b0);
                push_bus(32'h300, 4'b1111, 32'd0, 1'b0);
            end
        end
        rd_data = 32'h12345678; memWe = 1'b0; memFunc3 = 3'b010; memAddr = 32'h300; memWdata = 32'd0;
        ifAddr = 32'h400; ifReq = 1'b1; memReq = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (exp_resp.size() == 0) break;
        end
        ifReq = 1'b0; memReq = 1'b0;
        wait_drain("starve", 10);
        repeat (3) @(negedge clk);

        // Reset during WAIT, then a stray busRvalid: nothing comes out.
        base = if_pulses;
        rv_dly = 5;
        push_bus(32'h800, 4'b1111, 32'd0, 1'b0);
        rd_data = 32'h77777777; ifAddr = 32'h800; ifReq = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        nRst = 1'b0; ifReq = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_wait_no_ifValid", 32'(if_pulses - base), 32'd0);
        check("rst_wait_busReq", 32'(busReq), 32'd0);
        check("rst_wait_ifData", ifData, 32'd0);
        rv_dly = 0;
        if_op("if_after_reset", 32'h900, 32'h24682468);
        wait_drain("final", 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
